// File: rtl/data_bus_unit.sv
// data_bus_unit: data-side bus slave for the single-cycle core.
// Decodes a word RAM region and an MMIO window holding the LED register,
// a free-running cycle counter and a byte transmit queue with a
// valid/ready handshake toward a UART-style sink.
// Optional build macro: DATA_BUS_UNIT_DROP_CNT_EN adds an 8-bit saturating
// counter of dropped transmit pushes, readable at TXSTAT[15:8].
module data_bus_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16,
   parameter int RAM_WORDS  = 1024,
   parameter int TXQ_DEPTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] dataAddr,
   input  logic [DATA_WIDTH-1:0] dataOut,
   input  logic                  dataWrEnable,
   output logic [DATA_WIDTH-1:0] dataIn,
   output logic [7:0]            led,
   output logic [7:0]            txData,
   output logic                  txValid,
   input  logic                  txReady
);

   localparam int RAM_AW = $clog2(RAM_WORDS);
   localparam int TXQ_AW = $clog2(TXQ_DEPTH);
   localparam logic [ADDR_WIDTH:0]   RAM_BYTES   = (ADDR_WIDTH+1)'(4 * RAM_WORDS);
   localparam logic [ADDR_WIDTH-1:0] LED_ADDR    = ADDR_WIDTH'(32'h8000);
   localparam logic [ADDR_WIDTH-1:0] CYCLE_ADDR  = ADDR_WIDTH'(32'h8004);
   localparam logic [ADDR_WIDTH-1:0] TXDATA_ADDR = ADDR_WIDTH'(32'h8008);
   localparam logic [ADDR_WIDTH-1:0] TXSTAT_ADDR = ADDR_WIDTH'(32'h800C);
   localparam logic [TXQ_AW:0]       TXQ_FULL    = (TXQ_AW+1)'(TXQ_DEPTH);

   logic [DATA_WIDTH-1:0] r_ram [RAM_WORDS];
   logic [7:0]            r_led;
   logic [31:0]           r_cycle;
   logic [7:0]            r_txq [TXQ_DEPTH];
   logic [TXQ_AW-1:0]     r_head;
   logic [TXQ_AW-1:0]     r_tail;
   logic [TXQ_AW:0]       r_count;

   logic [ADDR_WIDTH-1:0] w_wordAddr;
   logic [RAM_AW-1:0]     w_ramIdx;
   logic                  w_ramSel;
   logic                  w_ledSel;
   logic                  w_cycleSel;
   logic                  w_txDataSel;
   logic                  w_txStatSel;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_pop;
   logic                  w_pushReq;
   logic                  w_push;
   logic [7:0]            w_dropBits;

   // The low two address bits never take part in decode; RAM wins over
   // MMIO so an oversized RAM cannot be shadowed, and MMIO words above the
   // RAM region never fold back into it.
   assign w_wordAddr  = {dataAddr[ADDR_WIDTH-1:2], 2'b00};
   assign w_ramIdx    = dataAddr[RAM_AW+1:2];
   assign w_ramSel    = {1'b0, dataAddr} < RAM_BYTES;
   assign w_ledSel    = !w_ramSel && (w_wordAddr == LED_ADDR);
   assign w_cycleSel  = !w_ramSel && (w_wordAddr == CYCLE_ADDR);
   assign w_txDataSel = !w_ramSel && (w_wordAddr == TXDATA_ADDR);
   assign w_txStatSel = !w_ramSel && (w_wordAddr == TXSTAT_ADDR);

   // A push into a full queue still succeeds when the head leaves in the
   // same cycle, so the sink never forces a drop while it is draining.
   assign w_full    = (r_count == TXQ_FULL);
   assign w_empty   = (r_count == '0);
   assign w_pop     = txValid && txReady;
   assign w_pushReq = dataWrEnable && w_txDataSel;
   assign w_push    = w_pushReq && (!w_full || w_pop);

   assign led     = r_led;
   assign txValid = !w_empty;
   assign txData  = w_empty ? 8'h00 : r_txq[r_head];

   // RAM storage: synchronous write, never cleared, writes suppressed in reset.
   always_ff @(posedge clk) begin
      if (!rst && dataWrEnable && w_ramSel) begin
         r_ram[w_ramIdx] <= dataOut;
      end
   end

   // LED register keeps only the low byte of the written word.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_led <= 8'h00;
      end else if (dataWrEnable && w_ledSel) begin
         r_led <= dataOut[7:0];
      end
   end

   // Free-running cycle counter; a write clears it ahead of the increment.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cycle <= 32'd0;
      end else if (dataWrEnable && w_cycleSel) begin
         r_cycle <= 32'd0;
      end else begin
         r_cycle <= r_cycle + 32'd1;
      end
   end

   // Queue storage holds stale bytes harmlessly; only the pointers matter.
   always_ff @(posedge clk) begin
      if (!rst && w_push) begin
         r_txq[r_tail] <= dataOut[7:0];
      end
   end

   // Queue pointers wrap naturally at the power-of-two depth.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_tail <= r_tail + 1'b1;
         end
         if (w_pop) begin
            r_head <= r_head + 1'b1;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (w_pop && !w_push) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

`ifdef DATA_BUS_UNIT_DROP_CNT_EN
   logic [7:0] r_dropCnt;
   logic       w_drop;

   assign w_drop     = w_pushReq && w_full && !w_pop;
   assign w_dropBits = r_dropCnt;

   // Saturating count of bytes lost to a full queue; TXSTAT writes clear it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_dropCnt <= 8'h00;
      end else if (dataWrEnable && w_txStatSel) begin
         r_dropCnt <= 8'h00;
      end else if (w_drop && (r_dropCnt != 8'hFF)) begin
         r_dropCnt <= r_dropCnt + 8'h01;
      end
   end
`else
   assign w_dropBits = 8'h00;
`endif

   // Zero-latency read mux; unmapped addresses read back zero.
   always_comb begin
      dataIn = '0;
      if (w_ramSel) begin
         dataIn = r_ram[w_ramIdx];
      end else if (w_ledSel) begin
         dataIn = DATA_WIDTH'(r_led);
      end else if (w_cycleSel) begin
         dataIn = DATA_WIDTH'(r_cycle);
      end else if (w_txDataSel) begin
         dataIn = DATA_WIDTH'(r_count);
      end else if (w_txStatSel) begin
         dataIn = DATA_WIDTH'({w_dropBits, 6'b000000, w_empty, w_full});
      end
   end

endmodule

// File: tb/tb_data_bus_unit.sv
// tb_data_bus_unit: directed self-checking bench for data_bus_unit.
// Inputs change 1 time unit after a rising edge; outputs are compared
// 1 unit later, well before the next edge.
// Build macro DATA_BUS_UNIT_DROP_CNT_EN enables the drop-counter checks.
module tb_data_bus_unit;

   logic        clk;
   logic        rst;
   logic [15:0] dataAddr;
   logic [31:0] dataOut;
   logic        dataWrEnable;
   logic [31:0] dataIn;
   logic [7:0]  led;
   logic [7:0]  txData;
   logic        txValid;
   logic        txReady;

   int checks = 0;
   int errors = 0;

   data_bus_unit dut (
      .clk          (clk),
      .rst          (rst),
      .dataAddr     (dataAddr),
      .dataOut      (dataOut),
      .dataWrEnable (dataWrEnable),
      .dataIn       (dataIn),
      .led          (led),
      .txData       (txData),
      .txValid      (txValid),
      .txReady      (txReady)
   );

   // 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic writeWord(input logic [15:0] addr, input logic [31:0] data);
      dataAddr     = addr;
      dataOut      = data;
      dataWrEnable = 1'b1;
      tick();
      dataWrEnable = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      dataAddr = 16'h8004;
      #1;
      checks++;
      if (dataIn !== 32'd0) begin
         errors++;
         $display("[TB] FAIL reset_cycle: got %h expected %h", dataIn, 32'd0);
      end
      checks++;
      if (led !== 8'h00 || txValid !== 1'b0 || txData !== 8'h00) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got led=%h v=%b d=%h expected 00 0 00", led, txValid, txData);
      end
      dataAddr = 16'h800C;
      #1;
      checks++;
      if (dataIn !== 32'h0000_0002) begin
         errors++;
         $display("[TB] FAIL reset_txstat: got %h expected %h", dataIn, 32'h2);
      end
      rst = 1'b0;
   endtask

   task automatic test_ram();
      writeWord(16'h0010, 32'h1111_1111);
      writeWord(16'h0000, 32'h5555_AAAA);
      dataAddr     = 16'h0010;
      dataOut      = 32'hDEAD_BEEF;
      dataWrEnable = 1'b1;
      #1;
      checks++;
      if (dataIn !== 32'h1111_1111) begin
         errors++;
         $display("[TB] FAIL ram_same_cycle_old: got %h expected %h", dataIn, 32'h1111_1111);
      end
      tick();
      dataWrEnable = 1'b0;
      #1;
      checks++;
      if (dataIn !== 32'hDEAD_BEEF) begin
         errors++;
         $display("[TB] FAIL ram_read_0010: got %h expected %h", dataIn, 32'hDEAD_BEEF);
      end
      dataAddr = 16'h0013;
      #1;
      checks++;
      if (dataIn !== 32'hDEAD_BEEF) begin
         errors++;
         $display("[TB] FAIL ram_read_0013: got %h expected %h", dataIn, 32'hDEAD_BEEF);
      end
      writeWord(16'h1000, 32'hCAFE_F00D);
      dataAddr = 16'h0000;
      #1;
      checks++;
      if (dataIn !== 32'h5555_AAAA) begin
         errors++;
         $display("[TB] FAIL ram_no_alias: got %h expected %h", dataIn, 32'h5555_AAAA);
      end
      dataAddr = 16'h1000;
      #1;
      checks++;
      if (dataIn !== 32'd0) begin
         errors++;
         $display("[TB] FAIL ram_above_top: got %h expected %h", dataIn, 32'd0);
      end
      writeWord(16'h0FFC, 32'h0BAD_CAFE);
      dataAddr = 16'h0FFC;
      #1;
      checks++;
      if (dataIn !== 32'h0BAD_CAFE) begin
         errors++;
         $display("[TB] FAIL ram_last_word: got %h expected %h", dataIn, 32'h0BAD_CAFE);
      end
   endtask

   task automatic test_led_unmapped();
      writeWord(16'h8000, 32'h1234_56A5);
      dataAddr = 16'h8000;
      #1;
      checks++;
      if (led !== 8'hA5 || dataIn !== 32'h0000_00A5) begin
         errors++;
         $display("[TB] FAIL led_write: got led=%h rd=%h expected A5 000000a5", led, dataIn);
      end
      dataAddr = 16'h8010;
      #1;
      checks++;
      if (dataIn !== 32'd0) begin
         errors++;
         $display("[TB] FAIL unmapped_read: got %h expected %h", dataIn, 32'd0);
      end
      writeWord(16'h8010, 32'hFFFF_FFFF);
      dataAddr = 16'h8008;
      #1;
      checks++;
      if (led !== 8'hA5 || dataIn !== 32'd0 || txValid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL unmapped_write: got led=%h occ=%h v=%b expected A5 0 0", led, dataIn, txValid);
      end
   endtask

   task automatic test_counter();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
      end
      dataAddr = 16'h8004;
      #1;
      checks++;
      if (dataIn !== 32'd10) begin
         errors++;
         $display("[TB] FAIL cycle_after_10: got %0d expected %0d", dataIn, 10);
      end
      writeWord(16'h8004, 32'h0000_0123);
      #1;
      checks++;
      if (dataIn !== 32'd0) begin
         errors++;
         $display("[TB] FAIL cycle_clear: got %0d expected %0d", dataIn, 0);
      end
      tick();
      checks++;
      if (dataIn !== 32'd1) begin
         errors++;
         $display("[TB] FAIL cycle_resume: got %0d expected %0d", dataIn, 1);
      end
   endtask

   task automatic test_queue_fill();
      logic [7:0] bytesIn [5];
      bytesIn[0] = 8'h41;
      bytesIn[1] = 8'h42;
      bytesIn[2] = 8'h43;
      bytesIn[3] = 8'h44;
      bytesIn[4] = 8'h45;
      txReady = 1'b0;
      for (int i = 0; i < 5; i++) begin
         dataAddr     = 16'h8008;
         dataOut      = {24'hABCDEF, bytesIn[i]};
         dataWrEnable = 1'b1;
         #1;
         if (i == 0) begin
            checks++;
            if (txValid !== 1'b0) begin
               errors++;
               $display("[TB] FAIL tx_no_bypass: got %b expected 0", txValid);
            end
         end
         tick();
         dataWrEnable = 1'b0;
         if (i == 0) begin
            checks++;
            if (txValid !== 1'b1 || txData !== 8'h41) begin
               errors++;
               $display("[TB] FAIL tx_first_push: got v=%b d=%h expected 1 41", txValid, txData);
            end
         end
      end
      dataAddr = 16'h800C;
      #1;
      checks++;
      if (dataIn[1:0] !== 2'b01) begin
         errors++;
         $display("[TB] FAIL tx_full_flag: got %b expected 01", dataIn[1:0]);
      end
`ifdef DATA_BUS_UNIT_DROP_CNT_EN
      checks++;
      if (dataIn[15:8] !== 8'd1) begin
         errors++;
         $display("[TB] FAIL tx_drop_count: got %0d expected 1", dataIn[15:8]);
      end
`else
      checks++;
      if (dataIn[15:8] !== 8'd0) begin
         errors++;
         $display("[TB] FAIL tx_drop_bits_zero: got %0d expected 0", dataIn[15:8]);
      end
`endif
      dataAddr = 16'h8008;
      #1;
      checks++;
      if (dataIn !== 32'd4 || txData !== 8'h41) begin
         errors++;
         $display("[TB] FAIL tx_occupancy_full: got occ=%0d d=%h expected 4 41", dataIn, txData);
      end
   endtask

   task automatic test_queue_drain();
      logic [7:0] expOut [4];
      expOut[0] = 8'h42;
      expOut[1] = 8'h43;
      expOut[2] = 8'h44;
      expOut[3] = 8'h46;
      txReady      = 1'b1;
      dataAddr     = 16'h8008;
      dataOut      = 32'h0000_0046;
      dataWrEnable = 1'b1;
      tick();
      dataWrEnable = 1'b0;
      #1;
      checks++;
      if (dataIn !== 32'd4) begin
         errors++;
         $display("[TB] FAIL tx_push_pop_full: got occ=%0d expected 4", dataIn);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (txValid !== 1'b1 || txData !== expOut[i]) begin
            errors++;
            $display("[TB] FAIL tx_drain_%0d: got v=%b d=%h expected 1 %h", i, txValid, txData, expOut[i]);
         end
         tick();
      end
      dataAddr = 16'h800C;
      #1;
      checks++;
      if (txValid !== 1'b0 || dataIn[1:0] !== 2'b10) begin
         errors++;
         $display("[TB] FAIL tx_empty_after_drain: got v=%b stat=%b expected 0 10", txValid, dataIn[1:0]);
      end
      txReady = 1'b0;
   endtask

   task automatic test_mid_reset();
      writeWord(16'h8000, 32'h0000_005A);
      writeWord(16'h8008, 32'h0000_0061);
      writeWord(16'h8008, 32'h0000_0062);
      writeWord(16'h8008, 32'h0000_0063);
      dataAddr = 16'h8008;
      #1;
      checks++;
      if (dataIn !== 32'd3 || led !== 8'h5A) begin
         errors++;
         $display("[TB] FAIL pre_reset_state: got occ=%0d led=%h expected 3 5A", dataIn, led);
      end
      rst          = 1'b1;
      dataAddr     = 16'h8008;
      dataOut      = 32'h0000_0077;
      dataWrEnable = 1'b1;
      tick();
      rst          = 1'b0;
      dataWrEnable = 1'b0;
      #1;
      checks++;
      if (txValid !== 1'b0 || dataIn !== 32'd0 || led !== 8'h00 || txData !== 8'h00) begin
         errors++;
         $display("[TB] FAIL mid_reset_queue: got v=%b occ=%0d led=%h d=%h expected 0 0 00 00", txValid, dataIn, led, txData);
      end
      dataAddr = 16'h8004;
      #1;
      checks++;
      if (dataIn !== 32'd0) begin
         errors++;
         $display("[TB] FAIL mid_reset_cycle: got %0d expected 0", dataIn);
      end
      dataAddr = 16'h0010;
      #1;
      checks++;
      if (dataIn !== 32'hDEAD_BEEF) begin
         errors++;
         $display("[TB] FAIL mid_reset_ram_kept: got %h expected %h", dataIn, 32'hDEAD_BEEF);
      end
`ifdef DATA_BUS_UNIT_DROP_CNT_EN
      dataAddr = 16'h800C;
      #1;
      checks++;
      if (dataIn[15:8] !== 8'd0) begin
         errors++;
         $display("[TB] FAIL mid_reset_drop: got %0d expected 0", dataIn[15:8]);
      end
`endif
   endtask

   // Scenario sequence and final summary.
   initial begin
      rst          = 1'b1;
      dataAddr     = 16'h0000;
      dataOut      = 32'h0000_0000;
      dataWrEnable = 1'b0;
      txReady      = 1'b0;
      test_reset();
      test_ram();
      test_led_unmapped();
      test_counter();
      test_queue_fill();
      test_queue_drain();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/data_bus_unit.md
Name: data_bus_unit

Overview:
- Data-side bus slave directly downstream of the single-cycle CPU core.
- Consumes the core's data address, write data and write enable; returns read data in the same cycle.
- Decodes the address into a word RAM region and a small MMIO region:
  - LED register
  - free-running cycle counter
  - transmit queue with a valid/ready handshake toward a UART-style byte sink.

Parameters:
- DATA_WIDTH, 32, width of the data bus and of the RAM words.
- ADDR_WIDTH, 16, byte-address width of dataAddr.
- RAM_WORDS, 1024, number of RAM words; power of 2; RAM occupies byte addresses 0 .. 4*RAM_WORDS-1.
- TXQ_DEPTH, 4, transmit queue entries; power of 2, minimum 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- dataAddr  in  ADDR_WIDTH  byte address from the core.
- dataOut  in  DATA_WIDTH  write data from the core.
- dataWrEnable  in  1  write strobe from the core; the write commits at the rising edge.
- dataIn  out  DATA_WIDTH  read data to the core; combinational from dataAddr.
- led  out  8  LED register value.
- txData  out  8  byte at the head of the transmit queue.
- txValid  out  1  queue non-empty.
- txReady  in  1  sink accepts the byte when txValid && txReady.

Behaviour:
- Address decode:
  - Word-aligned; dataAddr[1:0] is ignored everywhere.
  - RAM is selected when dataAddr < 4*RAM_WORDS; word index is dataAddr[log2(RAM_WORDS)+1:2].
  - MMIO addresses (a word whose address is at or above 4*RAM_WORDS must not alias into RAM):
    - 0x8000 LED: read/write; bits[7:0] only; reads zero-extend.
    - 0x8004 CYCLE: read returns the counter; any write clears it.
    - 0x8008 TXDATA: write pushes dataOut[7:0]; read returns the current queue occupancy (0..TXQ_DEPTH).
    - 0x800C TXSTAT: read bit0 = full, bit1 = empty, bits[15:8] per optional feature, other bits 0; writes ignored.
  - Any other address reads 0; writes to it are ignored.
- Reads:
  - Fully combinational, zero latency; dataIn is valid in the same cycle as dataAddr.
  - RAM uses asynchronous read and synchronous write.
  - Read and write to the same RAM word in one cycle: dataIn shows the old value; the new value is visible next cycle.
- Reset (rst high at a rising edge), values visible after that edge:
  - led = 0.
  - Cycle counter = 0.
  - Queue empty, so txValid = 0.
  - Queue occupancy = 0.
  - txData = 0.
  - Drop counter = 0.
  - RAM contents are NOT cleared.
  - A write asserted in a reset cycle is discarded.
- Cycle counter:
  - Increments by 1 every non-reset cycle; wraps from 2^32-1 to 0.
  - Write cycle to CYCLE: the value after the edge is 0 (the clear takes priority over the increment).
- Transmit queue:
  - Circular buffer with head and tail pointers plus an occupancy count.
  - txData is the head entry; txValid = occupancy != 0. No same-cycle bypass: a push into an empty queue raises txValid one cycle later.
  - Pop happens when txValid && txReady at the edge.
  - A push is accepted when the queue is not full, or when it is full and a pop occurs in the same cycle.
  - Push and pop in the same cycle: occupancy unchanged; FIFO order preserved.
  - Push while full with no pop: the byte is dropped; queue state is unchanged.
  - Pointers wrap modulo TXQ_DEPTH.
  - txData is held stable while txValid && !txReady.

Optional Feature:
- Macro: DATA_BUS_UNIT_DROP_CNT_EN.
- Defined:
  - An 8-bit drop counter increments on every dropped TX push and saturates at 255.
  - The counter is readable at TXSTAT bits[15:8].
  - A write to TXSTAT clears the counter.
- Undefined:
  - No counter logic is built.
  - TXSTAT bits[15:8] read 0.
  - Writes to TXSTAT are ignored.

Test Plan:
- RAM: write 0xDEADBEEF to 0x0010, then read 0x0010 and 0x0013 the next cycle -> both return 0xDEADBEEF; a same-cycle read during the write returns the prior value.
- LED and unmapped: write 0x1234_56A5 to 0x8000 -> led = 0xA5, read returns 0x0000_00A5; read 0x8010 -> 0; write to 0x8010 -> no state change.
- Counter: release reset, wait 10 cycles, read 0x8004 -> 10; write 0x8004 -> read 0 on the next cycle and 1 on the cycle after.
- Queue fill and drop: txReady = 0, push 0x41..0x45 -> TXSTAT bit0 = 1, TXDATA read = 4, txData = 0x41; with DATA_BUS_UNIT_DROP_CNT_EN, TXSTAT[15:8] = 1.
- Queue drain and simultaneous push/pop:
  - Hold the queue full, set txReady = 1, push 0x46 in the same cycle -> push accepted, occupancy stays 4.
  - Subsequent pops yield 0x42, 0x43, 0x44, 0x46, then txValid = 0 and TXSTAT bit1 = 1.
- Mid-operation reset: with 3 bytes queued and led = 0x5A, assert rst for one cycle together with a write to 0x8008 -> after the edge txValid = 0, occupancy = 0, led = 0, counter = 0, and RAM words written earlier are unchanged.
